// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetch front-end: one outstanding memory request,
// responses buffered as {pc, inst} pairs in a small FIFO toward if_id.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_gnt,
  input  logic        inst_rvalid,
  input  logic [31:0] inst_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        id_ready
);
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, req_pc;
  logic          drop;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count, count_next;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic granted, rsp, push, pop, slot_free;

  assign granted    = (state == REQ) && inst_gnt;
  assign rsp        = (state == WAIT) && inst_rvalid;
  assign push       = rsp && !drop && !redirect_en;
  assign pop        = id_valid && id_ready;
  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  // A slot is judged after this cycle's push/pop so a pop while full
  // lets the next request go out on the very next cycle.
  assign slot_free  = count_next < DEPTH_C;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (slot_free) state_next = REQ;
      REQ:     if (inst_gnt) state_next = WAIT;
      WAIT:    if (inst_rvalid) state_next = slot_free ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
    // A redirect must still wait out a response the memory already owes us.
    if (redirect_en) begin
      if (granted || (state == WAIT && !inst_rvalid)) state_next = WAIT;
      else                                            state_next = REQ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      drop     <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      state <= state_next;
      if (redirect_en)  fetch_pc <= redirect_pc;
      else if (granted) fetch_pc <= fetch_pc + 32'd4;
      if (granted) req_pc <= fetch_pc;
      if (redirect_en)  drop <= granted || (state == WAIT && !inst_rvalid);
      else if (rsp)     drop <= 1'b0;
      if (redirect_en) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        count <= count_next;
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= req_pc;
      inst_mem[tail] <= inst_rdata;
    end
  end

  assign inst_req  = (state == REQ);
  assign inst_addr = fetch_pc;
  assign id_valid  = (count != '0);
  assign id_pc     = id_valid ? pc_mem[head]   : '0;
  assign id_inst   = id_valid ? inst_mem[head] : '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: the bench plays instruction memory and keeps a
// transaction-level model of what decode should see.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } entry_t;

  int tests = 0;
  int failures = 0;

  // Expected decode-side contents and the address stream the fetcher owes us.
  entry_t      model_q[$];
  logic [31:0] popped[$];
  logic [31:0] exp_fetch = 32'h0;
  int          epoch = 0;
  // The single response the memory model still owes.
  bit          pend = 1'b0;
  bit          pend_stray = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_epoch = 0;
  int          pend_lat = 0;
  bit          last_gnt = 1'b0;
  logic [31:0] last_gnt_addr = 32'h0;
  // Stimulus knobs.
  int gnt_pct = 100, ready_pct = 100, lat_min = 0, lat_max = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + (a >> 2);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of bus traffic: compare outputs, drive inputs, advance the model.
  task automatic applyStimulus(input bit redir, input logic [31:0] rpc);
    bit          rv, gn, rd, do_pop, do_push;
    logic [31:0] data;
    checkOutput("id_valid", {31'b0, id_valid}, {31'b0, model_q.size() != 0});
    if (model_q.size() != 0) begin
      checkOutput("id_pc", id_pc, model_q[0].pc);
      checkOutput("id_inst", id_inst, model_q[0].inst);
    end
    if (pend && !pend_stray) checkOutput("req_while_pending", {31'b0, inst_req}, 32'h0);

    rv   = pend && (pend_lat == 0);
    data = rv ? mem_word(pend_addr) : $urandom();
    gn   = inst_req && !pend && (int'($urandom_range(99)) < gnt_pct);
    rd   = int'($urandom_range(99)) < ready_pct;
    inst_rvalid = rv;
    inst_rdata  = data;
    inst_gnt    = gn;
    id_ready    = rd;
    redirect_en = redir;
    redirect_pc = rpc;
    if (gn) checkOutput("gnt_addr", inst_addr, exp_fetch);
    do_pop = (model_q.size() != 0) && rd;
    if (do_pop) popped.push_back(id_pc);

    @(posedge clk);
    do_push  = rv && !pend_stray && (pend_epoch == epoch) && !redir;
    last_gnt = gn;
    if (rv) pend = 1'b0;
    else if (pend) pend_lat--;
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back('{pc: pend_addr, inst: data});
    if (gn) begin
      pend          = 1'b1;
      pend_stray    = 1'b0;
      pend_addr     = exp_fetch;
      pend_epoch    = epoch;
      pend_lat      = int'($urandom_range(lat_max, lat_min));
      last_gnt_addr = exp_fetch;
      exp_fetch     = exp_fetch + 32'd4;
    end
    if (redir) begin
      model_q.delete();
      epoch++;
      exp_fetch = rpc;
    end
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          n;
    logic [31:0] rpc;
    rst = 1'b1;
    inst_gnt = 1'b0; inst_rvalid = 1'b0; inst_rdata = 32'h0;
    redirect_en = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_inst_req", {31'b0, inst_req}, 32'h0);
    checkOutput("rst_inst_addr", inst_addr, 32'h0);
    checkOutput("rst_id_valid", {31'b0, id_valid}, 32'h0);
    checkOutput("rst_id_pc", id_pc, 32'h0);
    checkOutput("rst_id_inst", id_inst, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("release_inst_req", {31'b0, inst_req}, 32'h1);
    checkOutput("release_inst_addr", inst_addr, 32'h0);
    checkOutput("release_id_valid", {31'b0, id_valid}, 32'h0);

    // Streaming: grant at once, data one cycle later, decode always ready.
    gnt_pct = 100; ready_pct = 100; lat_min = 0; lat_max = 0;
    repeat (9) applyStimulus(1'b0, 32'h0);
    checkOutput("stream_pops", popped.size(), 32'd4);
    for (int i = 0; i < 4; i++) checkOutput("stream_pc", popped[i], 32'(4 * i));

    // Redirect together with a returning response: the response is dropped.
    applyStimulus(1'b1, 32'h0);
    checkOutput("redir_rv_id_valid", {31'b0, id_valid}, 32'h0);
    checkOutput("redir_rv_inst_req", {31'b0, inst_req}, 32'h1);
    checkOutput("redir_rv_inst_addr", inst_addr, 32'h0);

    // Backpressure: fill, confirm fetch stalls, then drain in order.
    popped.delete();
    ready_pct = 0;
    repeat (14) applyStimulus(1'b0, 32'h0);
    checkOutput("full_inst_req", {31'b0, inst_req}, 32'h0);
    checkOutput("full_id_valid", {31'b0, id_valid}, 32'h1);
    checkOutput("full_id_pc", id_pc, 32'h0);
    ready_pct = 100; gnt_pct = 0;
    applyStimulus(1'b0, 32'h0);
    checkOutput("unfull_inst_req", {31'b0, inst_req}, 32'h1);
    checkOutput("unfull_inst_addr", inst_addr, 32'h10);
    gnt_pct = 100;
    repeat (10) applyStimulus(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) checkOutput("drain_pc", popped[i], 32'(4 * i));

    // Redirect while waiting for the response to 0x8.
    lat_min = 3; lat_max = 3;
    applyStimulus(1'b1, 32'h0);
    n = 0;
    while (!(last_gnt && last_gnt_addr == 32'h8) && n < 60) begin
      applyStimulus(1'b0, 32'h0);
      n++;
    end
    checkOutput("wait_gnt_8", {31'b0, n < 60}, 32'h1);
    applyStimulus(1'b1, 32'h100);
    checkOutput("redir_wait_inst_req", {31'b0, inst_req}, 32'h0);
    lat_min = 0; lat_max = 0;
    popped.delete();
    n = 0;
    while (popped.size() < 1 && n < 40) begin applyStimulus(1'b0, 32'h0); n++; end
    checkOutput("redir_wait_first_pc", popped.size() >= 1 ? popped[0] : 32'hDEAD_BEEF, 32'h100);

    // Redirect with a full FIFO and decode ready: everything flushed.
    ready_pct = 0;
    repeat (14) applyStimulus(1'b0, 32'h0);
    checkOutput("full2_id_valid", {31'b0, id_valid}, 32'h1);
    ready_pct = 100;
    applyStimulus(1'b1, 32'h400);
    checkOutput("redir_full_id_valid", {31'b0, id_valid}, 32'h0);

    // Redirect in REQ without a grant.
    gnt_pct = 0;
    n = 0;
    while (!inst_req && n < 20) begin applyStimulus(1'b0, 32'h0); n++; end
    applyStimulus(1'b1, 32'h200);
    checkOutput("redir_req_inst_req", {31'b0, inst_req}, 32'h1);
    checkOutput("redir_req_inst_addr", inst_addr, 32'h200);

    // Redirect in REQ with a grant the same cycle: granted fetch goes stale.
    gnt_pct = 100;
    applyStimulus(1'b1, 32'h300);
    checkOutput("redir_gnt_inst_req", {31'b0, inst_req}, 32'h0);
    popped.delete();
    n = 0;
    while (popped.size() < 1 && n < 40) begin applyStimulus(1'b0, 32'h0); n++; end
    checkOutput("redir_gnt_first_pc", popped.size() >= 1 ? popped[0] : 32'hDEAD_BEEF, 32'h300);

    // Fetch PC wraps from the top of the address space to zero.
    applyStimulus(1'b1, 32'hFFFF_FFF8);
    popped.delete();
    n = 0;
    while (popped.size() < 3 && n < 40) begin applyStimulus(1'b0, 32'h0); n++; end
    checkOutput("wrap_pc0", popped.size() >= 3 ? popped[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
    checkOutput("wrap_pc1", popped.size() >= 3 ? popped[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    checkOutput("wrap_pc2", popped.size() >= 3 ? popped[2] : 32'hDEAD_BEEF, 32'h0);

    // Asynchronous reset while a response is outstanding.
    lat_min = 4; lat_max = 4;
    n = 0;
    while (!pend && n < 20) begin applyStimulus(1'b0, 32'h0); n++; end
    checkOutput("async_pending", {31'b0, pend}, 32'h1);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_inst_req", {31'b0, inst_req}, 32'h0);
    checkOutput("async_id_valid", {31'b0, id_valid}, 32'h0);
    checkOutput("async_inst_addr", inst_addr, 32'h0);
    model_q.delete();
    epoch++;
    exp_fetch = 32'h0;
    pend_stray = 1'b1;
    #1 rst = 1'b0;
    lat_min = 0; lat_max = 0;
    popped.delete();
    n = 0;
    while (popped.size() < 2 && n < 40) begin applyStimulus(1'b0, 32'h0); n++; end
    checkOutput("async_first_pc", popped.size() >= 2 ? popped[0] : 32'hDEAD_BEEF, 32'h0);
    checkOutput("async_second_pc", popped.size() >= 2 ? popped[1] : 32'hDEAD_BEEF, 32'h4);

    // Randomised traffic with occasional redirects.
    gnt_pct = 70; ready_pct = 60; lat_min = 0; lat_max = 3;
    popped.delete();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 4) begin
        rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'h0000_FFFC);
        applyStimulus(1'b1, rpc);
      end else begin
        applyStimulus(1'b0, 32'h0);
      end
    end
    checkOutput("random_progress", {31'b0, popped.size() > 20}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
